// File: rtl/insn_prefetch_buffer.sv
// Instruction prefetcher: issues sequential OBI word reads ahead of the IF stage and queues {rdata, err, addr};
// one cycle from rvalid to out_valid_o, new requests throttled so outstanding + queued never exceeds DEPTH.
module insn_prefetch_buffer #(
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [29:0]       boot_addr_i,
    input  logic              fetch_en_i,
    input  logic              redirect_i,
    input  logic [ADDR_W-1:0] redirect_addr_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [31:0]       out_instr_o,
    output logic [ADDR_W-1:0] out_addr_o,
    output logic              out_err_o,
    output logic              busy_o,
    output logic              obi_req_o,
    input  logic              obi_gnt_i,
    output logic [ADDR_W-1:0] obi_addr_o,
    output logic              obi_we_o,
    output logic [3:0]        obi_be_o,
    output logic [31:0]       obi_wdata_o,
    input  logic              obi_rvalid_i,
    output logic              obi_rready_o,
    input  logic [31:0]       obi_rdata_i,
    input  logic              obi_err_i
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W:0]   DEPTH_W = (CNT_W + 1)'(DEPTH);

    typedef enum logic {RUN, HOLD} state_e;

    state_e            state_q, state_d;
    logic              en_q;
    logic              boot_q, boot_d;
    logic              stall_q, stall_d;
    logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d;
    logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
    logic [ADDR_W-1:0] addr_eff, redir_aligned;
    logic [CNT_W-1:0]  outst_q, outst_d, disc_q, disc_d, count_q, count_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  ia_wr_q, ia_wr_d, ia_rd_q, ia_rd_d;
    logic [31:0]       fifo_instr_q [DEPTH];
    logic [31:0]       fifo_instr_d [DEPTH];
    logic              fifo_err_q   [DEPTH];
    logic              fifo_err_d   [DEPTH];
    logic [ADDR_W-1:0] fifo_addr_q  [DEPTH];
    logic [ADDR_W-1:0] fifo_addr_d  [DEPTH];
    logic [ADDR_W-1:0] ia_mem_q     [DEPTH];
    logic [ADDR_W-1:0] ia_mem_d     [DEPTH];
    logic              pop, push, flush, fire, credit_ok;
    logic [CNT_W:0]    committed;
    logic              unused_bits;

    assign unused_bits   = ^redirect_addr_i[1:0];
    assign redir_aligned = {redirect_addr_i[ADDR_W-1:2], 2'b00};
    assign addr_eff      = boot_q ? ADDR_W'({boot_addr_i, 2'b00}) : fetch_addr_q;

    // Credit counts a same-cycle pop so a draining consumer can be refilled without a bubble.
    assign pop       = (count_q != '0) && out_ready_i;
    assign committed = {1'b0, outst_q} + {1'b0, count_q} - {{CNT_W{1'b0}}, pop};
    assign credit_ok = committed < DEPTH_W;
    assign obi_req_o = en_q && ((state_q == HOLD) || stall_q || (fetch_en_i && credit_ok));
    assign fire      = obi_req_o && obi_gnt_i;
    assign outst_d   = outst_q + CNT_W'(fire) - CNT_W'(obi_rvalid_i);

    always_comb begin
        state_d      = state_q;
        fetch_addr_d = fetch_addr_q;
        pend_addr_d  = pend_addr_q;
        boot_d       = boot_q;
        stall_d      = 1'b0;
        flush        = 1'b0;
        push         = 1'b0;
        disc_d       = disc_q - CNT_W'(obi_rvalid_i && (disc_q != '0));
        case (state_q)
            RUN: begin
                if (redirect_i) begin
                    flush  = 1'b1;
                    disc_d = outst_d;
                    boot_d = 1'b0;
                    if (obi_req_o && !obi_gnt_i) begin
                        state_d      = HOLD;
                        pend_addr_d  = redir_aligned;
                        fetch_addr_d = addr_eff;
                    end else begin
                        fetch_addr_d = redir_aligned;
                    end
                end else begin
                    push    = obi_rvalid_i && (disc_q == '0);
                    stall_d = obi_req_o && !obi_gnt_i;
                    if (fire) begin
                        fetch_addr_d = addr_eff + ADDR_W'(4);
                        boot_d       = 1'b0;
                    end
                end
            end
            HOLD: begin
                // Everything in flight here is stale, including the word still waiting for its grant.
                disc_d = outst_d;
                if (redirect_i) pend_addr_d = redir_aligned;
                if (obi_gnt_i) begin
                    fetch_addr_d = redirect_i ? redir_aligned : pend_addr_q;
                    boot_d       = 1'b0;
                    state_d      = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        fifo_instr_d = fifo_instr_q;
        fifo_err_d   = fifo_err_q;
        fifo_addr_d  = fifo_addr_q;
        ia_mem_d     = ia_mem_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        ia_wr_d      = ia_wr_q;
        ia_rd_d      = ia_rd_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                fifo_instr_d[wr_ptr_q] = obi_rdata_i;
                fifo_err_d[wr_ptr_q]   = obi_err_i;
                fifo_addr_d[wr_ptr_q]  = ia_mem_q[ia_rd_q];
                wr_ptr_d               = wr_ptr_q + PTR_W'(1);
            end
            if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
        // Issued-address queue survives redirects so it stays aligned with the responses still due.
        if (fire) begin
            ia_mem_d[ia_wr_q] = addr_eff;
            ia_wr_d           = ia_wr_q + PTR_W'(1);
        end
        if (obi_rvalid_i) ia_rd_d = ia_rd_q + PTR_W'(1);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= RUN;
            en_q         <= 1'b0;
            boot_q       <= 1'b1;
            stall_q      <= 1'b0;
            fetch_addr_q <= '0;
            pend_addr_q  <= '0;
            outst_q      <= '0;
            disc_q       <= '0;
            count_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            ia_wr_q      <= '0;
            ia_rd_q      <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_instr_q[i] <= '0;
                fifo_err_q[i]   <= 1'b0;
                fifo_addr_q[i]  <= '0;
                ia_mem_q[i]     <= '0;
            end
        end else begin
            state_q      <= state_d;
            en_q         <= 1'b1;
            boot_q       <= boot_d;
            stall_q      <= stall_d;
            fetch_addr_q <= fetch_addr_d;
            pend_addr_q  <= pend_addr_d;
            outst_q      <= outst_d;
            disc_q       <= disc_d;
            count_q      <= count_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            ia_wr_q      <= ia_wr_d;
            ia_rd_q      <= ia_rd_d;
            fifo_instr_q <= fifo_instr_d;
            fifo_err_q   <= fifo_err_d;
            fifo_addr_q  <= fifo_addr_d;
            ia_mem_q     <= ia_mem_d;
        end
    end

    assign out_valid_o  = count_q != '0;
    assign out_instr_o  = fifo_instr_q[rd_ptr_q];
    assign out_err_o    = fifo_err_q[rd_ptr_q];
    assign out_addr_o   = fifo_addr_q[rd_ptr_q];
    assign busy_o       = (outst_q != '0) || (disc_q != '0);
    assign obi_addr_o   = addr_eff;
    assign obi_we_o     = 1'b0;
    assign obi_be_o     = 4'hF;
    assign obi_wdata_o  = '0;
    assign obi_rready_o = 1'b1;

    a_req_hold: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        (obi_req_o && !obi_gnt_i) |=> (obi_req_o && $stable(obi_addr_o)));
    a_count: assert property (@(posedge clk_i) disable iff (!rst_n_i) count_q <= DEPTH_C);
    a_credit: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        ({1'b0, outst_q} + {1'b0, count_q}) <= DEPTH_W);
    a_no_push_full: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        !(push && (count_q == DEPTH_C)));

endmodule

// File: tb/tb_insn_prefetch_buffer.sv
// Bench for insn_prefetch_buffer: in-order OBI memory model plus a stream model of the expected fetch sequence.
module tb_insn_prefetch_buffer;

    localparam int DEPTH  = 2;
    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [29:0]       boot_addr_i;
    logic              fetch_en_i, redirect_i, out_ready_i;
    logic [ADDR_W-1:0] redirect_addr_i;
    logic              out_valid_o, out_err_o, busy_o;
    logic [31:0]       out_instr_o;
    logic [ADDR_W-1:0] out_addr_o, obi_addr_o;
    logic              obi_req_o, obi_gnt_i, obi_we_o, obi_rvalid_i, obi_rready_o, obi_err_i;
    logic [3:0]        obi_be_o;
    logic [31:0]       obi_wdata_o, obi_rdata_i;

    always #5 clk = ~clk;

    insn_prefetch_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .boot_addr_i(boot_addr_i), .fetch_en_i(fetch_en_i),
        .redirect_i(redirect_i), .redirect_addr_i(redirect_addr_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_instr_o(out_instr_o),
        .out_addr_o(out_addr_o), .out_err_o(out_err_o), .busy_o(busy_o),
        .obi_req_o(obi_req_o), .obi_gnt_i(obi_gnt_i), .obi_addr_o(obi_addr_o), .obi_we_o(obi_we_o),
        .obi_be_o(obi_be_o), .obi_wdata_o(obi_wdata_o), .obi_rvalid_i(obi_rvalid_i),
        .obi_rready_o(obi_rready_o), .obi_rdata_i(obi_rdata_i), .obi_err_i(obi_err_i)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } resp_t;

    resp_t       rq[$];
    logic [31:0] gnt_log[$];
    logic [31:0] seen_addr[$];
    logic        seen_err[$];

    int          vectors = 0;
    int          miscompares = 0;
    int          cyc, first_gnt_cyc, first_vld_cyc, outst_tb;
    int unsigned gnt_pct, rv_pct, max_lat;
    logic [31:0] exp_addr, prev_addr, nx_raddr;
    logic        prev_stall, prev_redirect;
    logic        nx_ready, nx_fetch_en, nx_redirect;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    function automatic logic err_of(input logic [31:0] a);
        return a[5:2] == 4'hF;
    endfunction

    // One clock: drive the bus model and next inputs at negedge, observe #1 later, before the posedge.
    task automatic step();
        resp_t r;
        @(negedge clk);
        out_ready_i     = nx_ready;
        fetch_en_i      = nx_fetch_en;
        redirect_i      = nx_redirect;
        redirect_addr_i = nx_raddr;
        nx_redirect     = 1'b0;
        obi_rvalid_i    = 1'b0;
        obi_rdata_i     = '0;
        obi_err_i       = 1'b0;
        if (rq.size() > 0 && rq[0].due <= cyc && $urandom_range(99, 0) < rv_pct) begin
            r            = rq.pop_front();
            obi_rvalid_i = 1'b1;
            obi_rdata_i  = instr_of(r.addr);
            obi_err_i    = err_of(r.addr);
            outst_tb--;
        end
        obi_gnt_i = $urandom_range(99, 0) < gnt_pct;
        #1;
        if (prev_stall) begin
            vectors++;
            if (obi_req_o !== 1'b1 || obi_addr_o !== prev_addr) begin
                miscompares++;
                $display("FAIL req_hold cyc=%0d: req=%b addr=%h, required req=1 addr=%h", cyc, obi_req_o, obi_addr_o, prev_addr);
            end
        end
        if (prev_redirect) begin
            vectors++;
            if (out_valid_o !== 1'b0) begin
                miscompares++;
                $display("FAIL valid_after_redirect cyc=%0d: out_valid=%b, required 0", cyc, out_valid_o);
            end
        end
        if (obi_req_o && obi_gnt_i) begin
            r.addr = obi_addr_o;
            r.due  = cyc + 1 + int'($urandom_range(max_lat, 0));
            rq.push_back(r);
            if (gnt_log.size() == 0) first_gnt_cyc = cyc;
            gnt_log.push_back(obi_addr_o);
            outst_tb++;
        end
        vectors++;
        if (outst_tb > DEPTH) begin
            miscompares++;
            $display("FAIL credit cyc=%0d: outstanding=%0d, required <= %0d", cyc, outst_tb, DEPTH);
        end
        if (out_valid_o && first_vld_cyc < 0) first_vld_cyc = cyc;
        if (out_valid_o && out_ready_i) begin
            vectors++;
            if (out_addr_o !== exp_addr || out_instr_o !== instr_of(exp_addr) || out_err_o !== err_of(exp_addr)) begin
                miscompares++;
                $display("FAIL stream cyc=%0d: addr=%h instr=%h err=%b, required addr=%h instr=%h err=%b",
                         cyc, out_addr_o, out_instr_o, out_err_o, exp_addr, instr_of(exp_addr), err_of(exp_addr));
            end
            seen_addr.push_back(out_addr_o);
            seen_err.push_back(out_err_o);
            exp_addr = exp_addr + 32'd4;
        end
        if (redirect_i) exp_addr = {redirect_addr_i[31:2], 2'b00};
        prev_stall    = obi_req_o && !obi_gnt_i;
        prev_addr     = obi_addr_o;
        prev_redirect = redirect_i;
        cyc++;
    endtask

    task automatic apply_reset(input logic [29:0] boot);
        @(negedge clk);
        rst_n = 1'b0;
        boot_addr_i = boot;
        fetch_en_i = 1'b0; redirect_i = 1'b0; redirect_addr_i = '0; out_ready_i = 1'b0;
        obi_gnt_i = 1'b0; obi_rvalid_i = 1'b0; obi_rdata_i = '0; obi_err_i = 1'b0;
        nx_ready = 1'b1; nx_fetch_en = 1'b1; nx_redirect = 1'b0; nx_raddr = '0;
        gnt_pct = 100; rv_pct = 100; max_lat = 0;
        rq.delete(); gnt_log.delete(); seen_addr.delete(); seen_err.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cyc = 0; first_gnt_cyc = -1; first_vld_cyc = -1; outst_tb = 0;
        exp_addr = {boot, 2'b00};
        prev_stall = 1'b0; prev_redirect = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        boot_addr_i = 30'h0000_0020;
        fetch_en_i = 1'b1; out_ready_i = 1'b1; obi_gnt_i = 1'b1; redirect_i = 1'b0; redirect_addr_i = '0;
        obi_rvalid_i = 1'b0; obi_rdata_i = '0; obi_err_i = 1'b0;
        @(negedge clk);
        #1;
        vectors += 11;
        if (obi_req_o !== 1'b0)         begin miscompares++; $display("FAIL rst_req: %b, required 0", obi_req_o); end
        if (obi_addr_o !== 32'h80)      begin miscompares++; $display("FAIL rst_addr: %h, required 00000080", obi_addr_o); end
        if (out_valid_o !== 1'b0)       begin miscompares++; $display("FAIL rst_valid: %b, required 0", out_valid_o); end
        if (out_instr_o !== 32'h0)      begin miscompares++; $display("FAIL rst_instr: %h, required 0", out_instr_o); end
        if (out_addr_o !== 32'h0)       begin miscompares++; $display("FAIL rst_out_addr: %h, required 0", out_addr_o); end
        if (out_err_o !== 1'b0)         begin miscompares++; $display("FAIL rst_err: %b, required 0", out_err_o); end
        if (busy_o !== 1'b0)            begin miscompares++; $display("FAIL rst_busy: %b, required 0", busy_o); end
        if (obi_we_o !== 1'b0)          begin miscompares++; $display("FAIL we: %b, required 0", obi_we_o); end
        if (obi_be_o !== 4'hF)          begin miscompares++; $display("FAIL be: %h, required f", obi_be_o); end
        if (obi_wdata_o !== 32'h0)      begin miscompares++; $display("FAIL wdata: %h, required 0", obi_wdata_o); end
        if (obi_rready_o !== 1'b1)      begin miscompares++; $display("FAIL rready: %b, required 1", obi_rready_o); end
    endtask

    task automatic test_boot_seq();
        apply_reset(30'h0000_0020);
        repeat (12) step();
        vectors++;
        if (gnt_log.size() < 3) begin
            miscompares++; $display("FAIL boot_grants: %0d grants, required >= 3", gnt_log.size());
        end else if (gnt_log[0] !== 32'h80 || gnt_log[1] !== 32'h84 || gnt_log[2] !== 32'h88) begin
            miscompares++; $display("FAIL boot_addrs: %h %h %h, required 80 84 88", gnt_log[0], gnt_log[1], gnt_log[2]);
        end
        vectors++;
        if (first_gnt_cyc < 0 || first_vld_cyc != first_gnt_cyc + 2) begin
            miscompares++; $display("FAIL boot_latency: first valid cyc %0d, first gnt cyc %0d, required gnt+2", first_vld_cyc, first_gnt_cyc);
        end
        vectors++;
        if (seen_addr.size() < 3 || seen_addr[0] !== 32'h80) begin
            miscompares++; $display("FAIL boot_delivery: %0d words delivered, required >= 3 starting at 00000080", seen_addr.size());
        end
    endtask

    task automatic test_backpressure();
        apply_reset(30'h0000_0010);
        nx_ready = 1'b0;
        repeat (10) step();
        vectors += 2;
        if (gnt_log.size() != 2) begin miscompares++; $display("FAIL bp_fill: %0d grants, required 2", gnt_log.size()); end
        if (obi_req_o !== 1'b0) begin miscompares++; $display("FAIL bp_req_off: req=%b, required 0", obi_req_o); end
        nx_ready = 1'b1;
        step();
        nx_ready = 1'b0;
        repeat (8) step();
        vectors += 3;
        if (gnt_log.size() != 3) begin miscompares++; $display("FAIL bp_refill: %0d grants, required 3", gnt_log.size()); end
        if (seen_addr.size() != 1) begin miscompares++; $display("FAIL bp_pops: %0d pops, required 1", seen_addr.size()); end
        if (obi_req_o !== 1'b0) begin miscompares++; $display("FAIL bp_req_off2: req=%b, required 0", obi_req_o); end
    endtask

    task automatic test_redirect_flush();
        apply_reset(30'h0);
        rv_pct = 0;
        repeat (5) step();
        vectors++;
        if (gnt_log.size() != 2) begin miscompares++; $display("FAIL rf_outstanding: %0d grants, required 2", gnt_log.size()); end
        nx_redirect = 1'b1; nx_raddr = 32'h0000_1002;
        step();
        rv_pct = 100;
        repeat (10) step();
        vectors += 2;
        if (gnt_log.size() < 3 || gnt_log[2] !== 32'h1000) begin
            miscompares++; $display("FAIL rf_next_req: %0d grants, third %h, required 00001000", gnt_log.size(), gnt_log.size() >= 3 ? gnt_log[2] : 32'h0);
        end
        if (seen_addr.size() < 1 || seen_addr[0] !== 32'h1000) begin
            miscompares++; $display("FAIL rf_first_out: %0d delivered, required first 00001000", seen_addr.size());
        end
    endtask

    task automatic test_hold_redirect();
        apply_reset(30'h0000_0100);
        gnt_pct = 0;
        step();
        nx_redirect = 1'b1; nx_raddr = 32'h0000_0200;
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++;
            if (obi_req_o !== 1'b1 || obi_addr_o !== 32'h400) begin
                miscompares++; $display("FAIL hold_stable %0d: req=%b addr=%h, required req=1 addr=00000400", i, obi_req_o, obi_addr_o);
            end
        end
        gnt_pct = 100;
        repeat (10) step();
        vectors += 2;
        if (gnt_log.size() < 2 || gnt_log[0] !== 32'h400 || gnt_log[1] !== 32'h200) begin
            miscompares++; $display("FAIL hold_order: %0d grants, required 00000400 then 00000200", gnt_log.size());
        end
        if (seen_addr.size() < 1 || seen_addr[0] !== 32'h200) begin
            miscompares++; $display("FAIL hold_discard: %0d delivered, required first 00000200", seen_addr.size());
        end
    endtask

    task automatic test_wrap_err();
        int n, m;
        apply_reset(30'h0);
        step();
        nx_redirect = 1'b1; nx_raddr = 32'hFFFF_FFFC;
        step();
        n = gnt_log.size();
        m = seen_addr.size();
        repeat (8) step();
        vectors += 2;
        if (gnt_log.size() < n + 2 || gnt_log[n] !== 32'hFFFF_FFFC || gnt_log[n+1] !== 32'h0) begin
            miscompares++; $display("FAIL wrap_addr: grants after redirect %0d, required fffffffc then 00000000", gnt_log.size() - n);
        end
        if (seen_addr.size() < m + 2 || seen_addr[m] !== 32'hFFFF_FFFC || seen_err[m] !== 1'b1 || seen_err[m+1] !== 1'b0) begin
            miscompares++; $display("FAIL wrap_err: delivered %0d, required fffffffc with err=1 then err=0", seen_addr.size() - m);
        end
    endtask

    task automatic test_random();
        apply_reset(30'($urandom));
        gnt_pct = 60; rv_pct = 60; max_lat = 3;
        for (int i = 0; i < 10000; i++) begin
            nx_ready    = $urandom_range(99, 0) < 70;
            nx_fetch_en = $urandom_range(99, 0) < 90;
            if ($urandom_range(99, 0) < 2) begin
                nx_redirect = 1'b1;
                nx_raddr    = $urandom;
            end
            step();
        end
        vectors++;
        if (seen_addr.size() < 500) begin
            miscompares++; $display("FAIL random_progress: %0d words delivered, required >= 500", seen_addr.size());
        end
    endtask

    initial begin
        test_reset();
        test_boot_seq();
        test_backpressure();
        test_redirect_flush();
        test_hold_redirect();
        test_wrap_err();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
